// File: rtl/nes_fb_writer.sv
// PPU pixel-stream to framebuffer writer: filters visible dots, buffers them in a
// first-word-fall-through FIFO, and reports frame boundaries and overflow drops.
module nes_fb_writer #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [5:0]  pix_color,
  input  logic [2:0]  pix_emphasis,
  input  logic [8:0]  pix_x,
  input  logic [8:0]  pix_y,
  output logic [15:0] fb_addr,
  output logic [8:0]  fb_data,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic        frame_start,
  output logic        frame_done,
  output logic [6:0]  fifo_level,
  output logic [7:0]  drop_count
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [6:0]  DEPTH_L = 7'(FIFO_DEPTH);

  // Entry layout: {emphasis[2:0], color[5:0], y[7:0], x[7:0]}
  logic [24:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [6:0]    r_level;
  logic [7:0]    r_drop;
  logic          r_frame_start;
  logic          r_frame_done;

  logic          w_visible;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [24:0]   w_wr_word;
  logic [24:0]   w_head;

  assign w_visible = enable && !pix_x[8] && (pix_y < 9'd240);
  assign w_full    = (r_level == DEPTH_L);
  assign w_pop     = fb_valid && fb_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push    = w_visible && (!w_full || w_pop);
  assign w_drop    = w_visible && w_full && !w_pop;
  assign w_wr_word = {pix_emphasis, pix_color, pix_y[7:0], pix_x[7:0]};
  assign w_head    = r_mem[r_rd_ptr];

  assign fb_valid    = (r_level != '0);
  assign fb_addr     = fb_valid ? w_head[15:0]  : '0;
  assign fb_data     = fb_valid ? w_head[24:16] : '0;
  assign fifo_level  = r_level;
  assign drop_count  = r_drop;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_drop        <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_start <= w_push && (w_wr_word[15:0] == 16'h0000);
      r_frame_done  <= w_pop && (w_head[15:0] == 16'hEFFF);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 7'd1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 7'd1;
      end
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

endmodule
